// File: rtl/sprite_scheduler_if.sv
// Print-path port bundle of the sprite scheduler: beam position and register-bank read port in,
// committed per-line slot list out.
interface sprite_scheduler_if #(
    parameter int unsigned MAX_SLOTS = 4
);
    logic [10:0]             pixel_x;
    logic [9:0]              pixel_y;
    logic [29:0]             data_reg;
    logic [4:0]              n_register;
    logic [MAX_SLOTS-1:0]    slot_valid;
    logic [10*MAX_SLOTS-1:0] slot_x;
    logic [9*MAX_SLOTS-1:0]  slot_offset;
    logic [5*MAX_SLOTS-1:0]  slot_row;
    logic                    scanning;
    logic                    overflow;

    modport master (
        input  pixel_x, pixel_y, data_reg,
        output n_register, slot_valid, slot_x, slot_offset, slot_row, scanning, overflow
    );

    modport slave (
        output pixel_x, pixel_y, data_reg,
        input  n_register, slot_valid, slot_x, slot_offset, slot_row, scanning, overflow
    );
endinterface

// File: rtl/sprite_scheduler.sv
// Per-line sprite scheduler: scans the register bank during hblank and commits a slot list.
// Macro SCHED_OVERFLOW_EN: full scan every line and overflow reporting; otherwise early stop.
module sprite_scheduler #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned N_REGS      = 32,
    parameter int unsigned MAX_SLOTS   = 4,
    parameter int unsigned SPRITE_SIZE = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    sprite_scheduler_if.master bus
);
    localparam int unsigned CntW = $clog2(MAX_SLOTS + 1);

`ifdef SCHED_OVERFLOW_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e state_q, state_d;

    logic [10:0]     next_y_q;
    logic [4:0]      n_reg_q;
    logic            issue_q;
    logic            pipe_valid_q;
    logic [4:0]      pipe_idx_q;
    logic [CntW-1:0] hit_cnt_q;
    logic            sh_ovf_q;
    logic [9:0]      sh_x_q   [MAX_SLOTS];
    logic [8:0]      sh_off_q [MAX_SLOTS];
    logic [4:0]      sh_row_q [MAX_SLOTS];

    logic [MAX_SLOTS-1:0]    valid_q;
    logic [10*MAX_SLOTS-1:0] x_q;
    logic [9*MAX_SLOTS-1:0]  off_q;
    logic [5*MAX_SLOTS-1:0]  row_q;
    logic                    ovf_q;

    logic        spr_en;
    logic [9:0]  spr_x;
    logic [10:0] spr_y;
    logic [8:0]  spr_off;
    logic        trigger, line_end, hit, slots_full, last_idx, stop_early;
    logic        scan_start, do_commit, commit_empty;

    assign spr_en  = bus.data_reg[29];
    assign spr_x   = bus.data_reg[28:19];
    assign spr_y   = {1'b0, bus.data_reg[18:9]};
    assign spr_off = bus.data_reg[8:0];

    assign trigger    = bus.pixel_x == 11'(H_ACTIVE);
    assign line_end   = bus.pixel_x == 11'(H_TOTAL - 1);
    assign hit        = (state_q == StScan) && pipe_valid_q && spr_en &&
                        (next_y_q < 11'(V_ACTIVE)) && (spr_y <= next_y_q) &&
                        (next_y_q < spr_y + 11'(SPRITE_SIZE));
    assign slots_full = hit_cnt_q == CntW'(MAX_SLOTS);
    assign last_idx   = pipe_valid_q && (pipe_idx_q == 5'(N_REGS - 1));
    // Without overflow reporting there is nothing to learn past the last free slot.
    assign stop_early = !OvfEn && hit && (hit_cnt_q == CntW'(MAX_SLOTS - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        scan_start   = 1'b0;
        do_commit    = 1'b0;
        commit_empty = 1'b0;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d    = StScan;
                    scan_start = 1'b1;
                end
            end
            StScan: begin
                if (line_end) begin
                    state_d      = StIdle;
                    commit_empty = 1'b1;
                end else if (last_idx || stop_early) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (trigger) begin
                    state_d    = StScan;
                    scan_start = 1'b1;
                end else if (line_end) begin
                    state_d   = StIdle;
                    do_commit = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            next_y_q     <= '0;
            n_reg_q      <= '0;
            issue_q      <= 1'b0;
            pipe_valid_q <= 1'b0;
            pipe_idx_q   <= '0;
            hit_cnt_q    <= '0;
            sh_ovf_q     <= 1'b0;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                sh_x_q[i]   <= '0;
                sh_off_q[i] <= '0;
                sh_row_q[i] <= '0;
            end
            valid_q <= '0;
            x_q     <= '0;
            off_q   <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (scan_start) begin
                next_y_q     <= (bus.pixel_y == 10'(V_TOTAL - 1)) ? 11'd0
                                                                  : 11'(bus.pixel_y) + 11'd1;
                n_reg_q      <= '0;
                issue_q      <= 1'b1;
                pipe_valid_q <= 1'b0;
                hit_cnt_q    <= '0;
                sh_ovf_q     <= 1'b0;
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    sh_x_q[i]   <= '0;
                    sh_off_q[i] <= '0;
                    sh_row_q[i] <= '0;
                end
            end else if (state_q == StScan) begin
                // pipe_idx tags which register the data_reg of the next cycle belongs to
                pipe_valid_q <= issue_q && !stop_early;
                pipe_idx_q   <= n_reg_q;
                if (stop_early || (issue_q && n_reg_q == 5'(N_REGS - 1))) begin
                    issue_q <= 1'b0;
                end else if (issue_q) begin
                    n_reg_q <= n_reg_q + 5'd1;
                end
                if (hit && slots_full) begin
                    sh_ovf_q <= 1'b1;
                end else if (hit) begin
                    hit_cnt_q <= hit_cnt_q + CntW'(1);
                    for (int i = 0; i < MAX_SLOTS; i++) begin
                        if (hit_cnt_q == CntW'(i)) begin
                            sh_x_q[i]   <= spr_x;
                            sh_off_q[i] <= spr_off;
                            sh_row_q[i] <= 5'(next_y_q - spr_y);
                        end
                    end
                end
            end else begin
                pipe_valid_q <= 1'b0;
            end

            if (do_commit) begin
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    valid_q[i]         <= CntW'(i) < hit_cnt_q;
                    x_q[10*i +: 10]    <= sh_x_q[i];
                    off_q[9*i +: 9]    <= sh_off_q[i];
                    row_q[5*i +: 5]    <= sh_row_q[i];
                end
                ovf_q <= OvfEn && sh_ovf_q;
            end else if (commit_empty) begin
                valid_q <= '0;
                x_q     <= '0;
                off_q   <= '0;
                row_q   <= '0;
                ovf_q   <= OvfEn;
            end
        end
    end

    assign bus.n_register  = n_reg_q;
    assign bus.slot_valid  = valid_q;
    assign bus.slot_x      = x_q;
    assign bus.slot_offset = off_q;
    assign bus.slot_row    = row_q;
    assign bus.scanning    = state_q == StScan;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: per-line expectations from a list-based reference model,
// popped and compared by a monitor at every commit.
module tb_sprite_scheduler;
    localparam int H_ACTIVE = 640, H_TOTAL = 800, V_ACTIVE = 480, V_TOTAL = 525;
    localparam int N_REGS = 32, MAX_SLOTS = 4, SPRITE_SIZE = 20;
`ifdef SCHED_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    typedef struct {
        logic [3:0]  valid;
        logic [39:0] x;
        logic [35:0] off;
        logic [19:0] row;
        logic        ovf;
        int          scan_len;
        bit          chk_scan;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] bank [N_REGS];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;

    sprite_scheduler_if #(.MAX_SLOTS(MAX_SLOTS)) bus ();

    sprite_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Register bank: read data appears one clock after the address.
    always @(posedge clk) bus.data_reg <= bank[bus.n_register];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic exp_t model(input int py);
        exp_t e;
        int   ny, sy;
        int   hits [$];
        e = '{default: 0};
        ny = (py == V_TOTAL - 1) ? 0 : py + 1;
        for (int k = 0; k < N_REGS; k++) begin
            sy = int'(bank[k][18:9]);
            if (bank[k][29] && ny < V_ACTIVE && sy <= ny && ny < sy + SPRITE_SIZE)
                hits.push_back(k);
        end
        for (int s = 0; s < hits.size() && s < MAX_SLOTS; s++) begin
            sy = int'(bank[hits[s]][18:9]);
            e.valid[s]       = 1'b1;
            e.x[10*s +: 10]  = bank[hits[s]][28:19];
            e.off[9*s +: 9]  = bank[hits[s]][8:0];
            e.row[5*s +: 5]  = 5'(ny - sy);
        end
        e.ovf      = OVF && hits.size() > MAX_SLOTS;
        e.scan_len = (!OVF && hits.size() >= MAX_SLOTS) ? hits[MAX_SLOTS-1] + 2 : N_REGS + 1;
        e.chk_scan = 1'b1;
        return e;
    endfunction

    // Monitor: pops one expectation per commit and checks outputs stay put in between.
    exp_t cur = '{default: 0};
    bit   commit_pending = 1'b0;
    bit   rst_seen = 1'b0;
    bit   line_bad = 1'b0;
    int   scan_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) cur = '{default: 0};
        if (commit_pending) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("slot_valid", 64'(bus.slot_valid), 64'(e.valid));
                chk("slot_x", 64'(bus.slot_x), 64'(e.x));
                chk("slot_offset", 64'(bus.slot_offset), 64'(e.off));
                chk("slot_row", 64'(bus.slot_row), 64'(e.row));
                chk("overflow", 64'(bus.overflow), 64'(e.ovf));
                if (e.chk_scan) chk("scan_cycles", 64'(scan_cnt), 64'(e.scan_len));
                chk("stable_outputs", 64'(line_bad), 64'd0);
                cur = e;
            end
            scan_cnt = 0;
            line_bad = 1'b0;
        end else if (bus.slot_valid !== cur.valid || bus.slot_x !== cur.x ||
                     bus.slot_offset !== cur.off || bus.slot_row !== cur.row ||
                     bus.overflow !== cur.ovf) begin
            line_bad = 1'b1;
        end
        if (bus.scanning === 1'b1) scan_cnt++;
        rst_seen       = (reset_n == 1'b0);
        commit_pending = (bus.pixel_x == 11'(H_TOTAL - 1)) && reset_n;
    end

    task automatic drive_line(input int py, input bit do_rst, input bit chk_nreg);
        exp_t e;
        bit   rst_now = 1'b0;
        bit   nreg_bad = 1'b0;
        int   k;
        if (do_rst) begin
            e = '{default: 0};
        end else begin
            e = model(py);
        end
        exp_q.push_back(e);
        for (int x = 0; x < H_TOTAL; x++) begin
            @(posedge clk);
            #1;
            if (rst_now) begin
                reset_n = 1'b1;
                rst_now = 1'b0;
                chk("rst_scanning", 64'(bus.scanning), 64'd0);
                chk("rst_slot_valid", 64'(bus.slot_valid), 64'd0);
                chk("rst_slot_x", 64'(bus.slot_x), 64'd0);
                chk("rst_overflow", 64'(bus.overflow), 64'd0);
                chk("rst_n_register", 64'(bus.n_register), 64'd0);
            end
            bus.pixel_x = 11'(x);
            bus.pixel_y = 10'(py);
            if (chk_nreg && x > H_ACTIVE) begin
                k = (x - H_ACTIVE - 1 > N_REGS - 1) ? N_REGS - 1 : x - H_ACTIVE - 1;
                if (bus.n_register !== 5'(k)) nreg_bad = 1'b1;
            end
            if (do_rst && x == H_ACTIVE + 10) begin
                reset_n = 1'b0;
                rst_now = 1'b1;
            end
        end
        if (chk_nreg) chk("n_register_seq", 64'(nreg_bad), 64'd0);
    endtask

    task automatic clear_bank();
        for (int k = 0; k < N_REGS; k++) bank[k] = '0;
    endtask

    task automatic random_bank(input int py);
        int base;
        base = (py > 15) ? py - 15 : 0;
        for (int k = 0; k < N_REGS; k++) begin
            bank[k][29]    = ($urandom_range(0, 3) != 0);
            bank[k][28:19] = 10'($urandom);
            bank[k][18:9]  = 10'(base + int'($urandom_range(0, 25)));
            bank[k][8:0]   = 9'($urandom);
        end
    endtask

    initial begin
        int py;
        clear_bank();
        reset_n     = 1'b0;
        bus.pixel_x = '0;
        bus.pixel_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_n_register", 64'(bus.n_register), 64'd0);
        chk("reset_slot_valid", 64'(bus.slot_valid), 64'd0);
        chk("reset_slot_x", 64'(bus.slot_x), 64'd0);
        chk("reset_slot_offset", 64'(bus.slot_offset), 64'd0);
        chk("reset_slot_row", 64'(bus.slot_row), 64'd0);
        chk("reset_scanning", 64'(bus.scanning), 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);
        reset_n = 1'b1;

        // Single sprite at y=10: hit, then the vertical edges of the sprite.
        bank[3] = {1'b1, 10'd100, 10'd10, 9'd7};
        drive_line(14, 1'b0, 1'b1);
        drive_line(8, 1'b0, 1'b0);
        drive_line(9, 1'b0, 1'b0);
        drive_line(28, 1'b0, 1'b0);
        drive_line(29, 1'b0, 1'b0);

        // Six sprites at y=0: slot saturation, plus the frame wrap.
        clear_bank();
        for (int k = 0; k < 6; k++) bank[k] = {1'b1, 10'(10 * k + 5), 10'd0, 9'(k + 1)};
        drive_line(0, 1'b0, 1'b0);
        drive_line(V_TOTAL - 1, 1'b0, 1'b0);

        // next_y past the active area: empty list despite matching sprites.
        for (int k = 0; k < N_REGS; k++) bank[k] = {1'b1, 10'(k), 10'd470, 9'(k)};
        drive_line(V_ACTIVE - 1, 1'b0, 1'b0);

        // Mid-scan reset after a populated line, then a normal line.
        clear_bank();
        for (int k = 0; k < 6; k++) bank[k] = {1'b1, 10'(10 * k + 5), 10'd0, 9'(k + 1)};
        drive_line(0, 1'b0, 1'b0);
        drive_line(5, 1'b1, 1'b0);
        drive_line(0, 1'b0, 1'b0);

        for (int n = 0; n < 14; n++) begin
            py = int'($urandom_range(0, V_TOTAL - 1));
            random_bank((py == V_TOTAL - 1) ? 0 : py + 1);
            drive_line(py, 1'b0, 1'b0);
        end

        @(posedge clk);
        #1;
        bus.pixel_x = '0;
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Per-line sprite scheduler for the video print path. During each horizontal blanking interval it walks the sprite register bank and selects up to MAX_SLOTS sprites that intersect the next scanline. It latches their x position, memory offset and row index into a double-buffered slot list, which the pixel printer reads on the following active line. It owns the register-bank read port (`n_register`) on behalf of the print path.

## Interface
- H_ACTIVE, 640, active pixels per line.
- H_TOTAL, 800, total pixel clocks per line (pixel_x runs 0..H_TOTAL-1).
- V_ACTIVE, 480, active lines.
- V_TOTAL, 525, total lines (pixel_y runs 0..V_TOTAL-1).
- N_REGS, 32, sprite registers scanned per line; N_REGS+3 must not exceed H_TOTAL-H_ACTIVE.
- MAX_SLOTS, 4, sprites kept per line.
- SPRITE_SIZE, 20, sprite height in lines.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pixel_x  in  11  current horizontal counter.
- pixel_y  in  10  current vertical counter.
- data_reg  in  30  register bank read data for `n_register`, valid one clock after address; [29] enable, [28:19] x, [18:9] y, [8:0] memory offset.
- n_register  out  5  register bank read address.
- slot_valid  out  MAX_SLOTS  active list: slot occupied.
- slot_x  out  10*MAX_SLOTS  active list x, slot i at [10i+9:10i].
- slot_offset  out  9*MAX_SLOTS  active list memory offset.
- slot_row  out  5*MAX_SLOTS  active list row within sprite (next_y - y).
- scanning  out  1  high while the FSM is in SCAN.
- overflow  out  1  more than MAX_SLOTS hits on the line committed last.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on the cycle pixel_x == H_ACTIVE.
  - On that cycle: next_y <= (pixel_y == V_TOTAL-1) ? 0 : pixel_y+1.
  - Clear the shadow list and hit count.
  - n_register <= 0.
- SCAN:
  - n_register increments each cycle up to N_REGS-1, then holds.
  - A one-cycle valid pipe tags the index whose data_reg is present.
  - Hit condition: enable=1, next_y < V_ACTIVE, y <= next_y, and next_y < y+SPRITE_SIZE. Compare at 11 bits; no wrap.
  - On a hit, write the next free shadow slot, in ascending register index order. Lower index always wins a slot.
  - A hit with all slots full sets shadow overflow.
  - After index N_REGS-1 is evaluated, go to DONE.
- DONE -> IDLE on pixel_x == H_TOTAL-1: commit the shadow list and overflow to the outputs.
- Commit on pixel_x == H_TOTAL-1 while still in SCAN (illegal parameters): commit an empty list with overflow=1, then go to IDLE.
- Trigger while in DONE (no commit seen, e.g. a counter jump): restart the scan; the old shadow list is discarded.
- Lines with next_y >= V_ACTIVE are still scanned and commit an empty list.

## Timing
- Trigger at cycle T:
  - n_register=0 at T+1, k at T+1+k.
  - Evaluation of index k happens at T+2+k.
  - DONE is entered at T+N_REGS+2; scanning is high from T+1 through T+N_REGS+1.
- Outputs change only at commit, i.e. the cycle after pixel_x == H_TOTAL-1. They are stable for the whole following line.
- Reset values: n_register=0, slot_valid=0, slot_x=0, slot_offset=0, slot_row=0, scanning=0, overflow=0, FSM=IDLE.
- reset_n low mid-scan aborts the scan and clears both lists; scanning restarts at the next pixel_x == H_ACTIVE.

## Configuration
- SCHED_OVERFLOW_EN defined:
  - The full N_REGS scan always runs.
  - overflow reports excess hits.
- SCHED_OVERFLOW_EN undefined:
  - SCAN ends once MAX_SLOTS hits are recorded; n_register holds and the FSM goes to DONE on the next cycle.
  - overflow is tied to 0.

## Test plan
- Reg 3 = {1, x=100, y=10, off=7}, all others disabled; pixel_y=14 line -> after commit slot_valid=0001, slot_x[0]=100, slot_offset[0]=7, slot_row[0]=5.
- Regs 0..5 enabled with y=0; line pixel_y=0 -> slots hold regs 0..3 in order. With SCHED_OVERFLOW_EN: overflow=1 and the scan takes 34 cycles. Without it: overflow=0 and DONE is entered 6 cycles after the trigger.
- Sprite y=10: lines pixel_y=8 and 29 -> empty; pixel_y=9 -> row 0; pixel_y=28 -> row 19.
- pixel_y=524 -> next_y=0, sprite y=0 hits with row 0; pixel_y=479 -> next_y=480, empty list despite enabled sprites.
- Hold reset_n=0 for one cycle at T+10 of a scan -> all outputs 0 and FSM IDLE, scanning=0; next line scans normally.
- Check n_register sequence 0..31 and that outputs are unchanged until the cycle after pixel_x=799.
